// File: rtl/idma_rd_pkg.sv
// Shared constants and FSM encoding for the iDMA read-data drain path.
package idma_rd_pkg;

    localparam int unsigned FIFO_WIDTH = 144;
    localparam int unsigned DATA_W     = 128;
    localparam int unsigned STRB_W     = 16;
    localparam int unsigned BEAT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ABORT = 2'd2
    } drain_state_e;

endpackage

// File: rtl/idma_skid_buf_2e.sv
// Two-entry in-order buffer with occupancy output; entry 0 is always the head.
module idma_skid_buf_2e #(
    parameter int unsigned W = 144
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] ent0_q, ent0_d;
    logic [W-1:0] ent1_q, ent1_d;
    logic [1:0]   occ_q, occ_d;

    // Next-state for the entries and occupancy; flush overrides any push/pop.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        if (flush_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_d = data_i;
                    end else begin
                        ent1_d = data_i;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_d = ent1_q;
                    occ_d  = occ_q - 2'd1;
                end
                2'b11: begin
                    // Simultaneous push/pop keeps occupancy; the new word lands behind the survivor.
                    if (occ_q == 2'd1) begin
                        ent0_d = data_i;
                    end else begin
                        ent0_d = ent1_q;
                        ent1_d = data_i;
                    end
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o = ent0_q;
    assign occ_o  = occ_q;

endmodule

// File: rtl/idma_rd_data_drain_128b.sv
// Drains N beats from a one-cycle-latency read FIFO into a valid/ready stream,
// with abort (FIFO flush) and completion pulse.
module idma_rd_data_drain_128b #(
    parameter int unsigned FIFO_WIDTH = idma_rd_pkg::FIFO_WIDTH,
    parameter int unsigned DATA_W     = idma_rd_pkg::DATA_W,
    parameter int unsigned STRB_W     = idma_rd_pkg::STRB_W,
    parameter int unsigned BEAT_W     = idma_rd_pkg::BEAT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  xfer_start,
    input  logic [BEAT_W-1:0]     xfer_beats,
    input  logic                  xfer_abort,
    output logic                  busy,
    output logic                  xfer_done,
    output logic                  data_fifo_pop,
    input  logic                  data_fifo_valid,
    input  logic [FIFO_WIDTH-1:0] data_fifo_data_out,
    input  logic                  data_fifo_empty,
    output logic                  data_fifo_init,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [STRB_W-1:0]     out_strb,
    output logic                  out_last
);

    import idma_rd_pkg::*;

    localparam logic [BEAT_W-1:0] BEAT_ONE = {{(BEAT_W-1){1'b0}}, 1'b1};

    drain_state_e          state_q, state_d;
    logic [BEAT_W-1:0]     beats_q, beats_d;
    logic [BEAT_W-1:0]     popped_q, popped_d;
    logic [BEAT_W-1:0]     sent_q, sent_d;
    logic                  inflight_q;
    logic                  done_q, done_d;
    logic                  init_q, init_d;
    logic                  pop_s, push_s, flush_s, fire_s;
    logic [1:0]            occ_s;
    logic [2:0]            load_s;
    logic [FIFO_WIDTH-1:0] head_s;

    idma_skid_buf_2e #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush_s),
        .push_i  (push_s),
        .data_i  (data_fifo_data_out),
        .pop_i   (fire_s),
        .head_o  (head_s),
        .occ_o   (occ_s)
    );

    assign out_valid = (state_q == ST_RUN) && (occ_s != 2'd0);
    assign out_data  = head_s[DATA_W-1:0];
    assign out_strb  = head_s[DATA_W +: STRB_W];
    assign out_last  = out_valid && (sent_q == (beats_q - BEAT_ONE));
    assign fire_s    = out_valid && out_ready;

    // Next-state, pop decision and pulse generation.
    always_comb begin
        state_d  = state_q;
        beats_d  = beats_q;
        popped_d = popped_q;
        sent_d   = sent_q;
        done_d   = 1'b0;
        init_d   = 1'b0;
        pop_s    = 1'b0;
        push_s   = 1'b0;
        flush_s  = 1'b0;
        // Words held or on their way once this cycle's beat (if any) leaves.
        load_s   = {1'b0, occ_s} + {2'b0, inflight_q} - {2'b0, fire_s};
        case (state_q)
            ST_IDLE: begin
                if (xfer_start && (xfer_beats != '0)) begin
                    state_d  = ST_RUN;
                    beats_d  = xfer_beats;
                    popped_d = '0;
                    sent_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                push_s = data_fifo_valid;
                if (fire_s && out_last) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    sent_d  = sent_q + BEAT_ONE;
                end else if (xfer_abort) begin
                    state_d = ST_ABORT;
                    init_d  = 1'b1;
                    flush_s = 1'b1;
                end else begin
                    pop_s = !data_fifo_empty && (popped_q != beats_q) && (load_s < 3'd2);
                    if (pop_s) begin
                        popped_d = popped_q + BEAT_ONE;
                    end else begin
                        popped_d = popped_q;
                    end
                    if (fire_s) begin
                        sent_d = sent_q + BEAT_ONE;
                    end else begin
                        sent_d = sent_q;
                    end
                end
            end
            ST_ABORT: begin
                // Any word arriving now was popped before the abort and is dropped.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            beats_q    <= '0;
            popped_q   <= '0;
            sent_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            init_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            popped_q   <= popped_d;
            sent_q     <= sent_d;
            inflight_q <= pop_s;
            done_q     <= done_d;
            init_q     <= init_d;
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign xfer_done      = done_q;
    assign data_fifo_init = init_q;
    assign data_fifo_pop  = pop_s;

endmodule

// File: tb/tb_idma_rd_data_drain_128b.sv
// Scoreboard bench: FIFO model and stimulus in one process, output monitor in another.
module tb_idma_rd_data_drain_128b;

    localparam int FW = 144;
    localparam int DW = 128;
    localparam int SW = 16;
    localparam int BW = 16;

    logic          clk;
    logic          rst_n;
    logic          xfer_start;
    logic [BW-1:0] xfer_beats;
    logic          xfer_abort;
    logic          busy;
    logic          xfer_done;
    logic          data_fifo_pop;
    logic          data_fifo_valid;
    logic [FW-1:0] data_fifo_data_out;
    logic          data_fifo_empty;
    logic          data_fifo_init;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [SW-1:0] out_strb;
    logic          out_last;

    idma_rd_data_drain_128b dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .xfer_start         (xfer_start),
        .xfer_beats         (xfer_beats),
        .xfer_abort         (xfer_abort),
        .busy               (busy),
        .xfer_done          (xfer_done),
        .data_fifo_pop      (data_fifo_pop),
        .data_fifo_valid    (data_fifo_valid),
        .data_fifo_data_out (data_fifo_data_out),
        .data_fifo_empty    (data_fifo_empty),
        .data_fifo_init     (data_fifo_init),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_data           (out_data),
        .out_strb           (out_strb),
        .out_last           (out_last)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
        logic          last;
    } beat_t;

    beat_t         exp_q[$];
    logic [FW-1:0] fq[$];
    int total = 0;
    int bad = 0;
    int pops_x = 0;
    int fires_x = 0;
    bit done_seen = 1'b0;
    bit load_chk = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample at negedge, apply FIFO model response 1 time unit after posedge.
    task automatic tick();
        logic pop_n, init_n;
        @(negedge clk);
        pop_n  = data_fifo_pop;
        init_n = data_fifo_init;
        check("pop_on_empty", {143'd0, pop_n && (fq.size() == 0)}, '0);
        if (xfer_done) done_seen = 1'b1;
        if (pop_n) pops_x++;
        if (out_valid && out_ready) fires_x++;
        @(posedge clk);
        #1;
        data_fifo_valid = 1'b0;
        if (pop_n && (fq.size() != 0)) begin
            data_fifo_data_out = fq.pop_front();
            data_fifo_valid    = 1'b1;
        end
        if (init_n) fq.delete();
        if (load_chk) check("load_le2", {143'd0, (pops_x - fires_x) <= 2}, 144'd1);
        data_fifo_empty = (fq.size() == 0);
    endtask

    task automatic push_word(input bit last);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        beat_t b;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        s = SW'($urandom_range(0, 65535));
        fq.push_back({s, d});
        b.data = d;
        b.strb = s;
        b.last = last;
        exp_q.push_back(b);
        data_fifo_empty = 1'b0;
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) push_word(i == n - 1);
    endtask

    task automatic start(input int n);
        xfer_beats = BW'(n);
        xfer_start = 1'b1;
        pops_x     = 0;
        fires_x    = 0;
        done_seen  = 1'b0;
        load_chk   = 1'b1;
        tick();
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done_seen; i++) tick();
        check("done_within_budget", {143'd0, done_seen}, 144'd1);
        check("exp_drained", FW'(exp_q.size()), '0);
    endtask

    // Monitor: scoreboard compare, hold stability and completion pulse timing.
    initial begin
        beat_t         e;
        logic          pv, pr, pa, done_exp, pl;
        logic [DW-1:0] pd;
        logic [SW-1:0] ps;
        pv = 1'b0; pr = 1'b0; pa = 1'b0; done_exp = 1'b0; pl = 1'b0;
        pd = '0; ps = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pv = 1'b0;
                done_exp = 1'b0;
            end else begin
                check("xfer_done_timing", {143'd0, xfer_done}, {143'd0, done_exp});
                if (pv && !pr && !pa) begin
                    check("hold_valid", {143'd0, out_valid}, 144'd1);
                    check("hold_data", FW'(out_data), FW'(pd));
                    check("hold_strb", FW'(out_strb), FW'(ps));
                    check("hold_last", {143'd0, out_last}, {143'd0, pl});
                end
                done_exp = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", 144'd1, 144'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", FW'(out_data), FW'(e.data));
                        check("beat_strb", FW'(out_strb), FW'(e.strb));
                        check("beat_last", {143'd0, out_last}, {143'd0, e.last});
                        done_exp = e.last;
                    end
                end
                pv = out_valid; pr = out_ready; pa = xfer_abort;
                pd = out_data;  ps = out_strb;  pl = out_last;
            end
        end
    end

    initial begin
        int n, k, pushed, abort_at;
        bit do_abort, aborted;
        rst_n = 1'b0; xfer_start = 1'b0; xfer_beats = '0; xfer_abort = 1'b0;
        data_fifo_valid = 1'b0; data_fifo_data_out = '0; data_fifo_empty = 1'b1;
        out_ready = 1'b0;
        repeat (3) tick();
        #3;
        check("rst_busy", {143'd0, busy}, '0);
        check("rst_done", {143'd0, xfer_done}, '0);
        check("rst_pop", {143'd0, data_fifo_pop}, '0);
        check("rst_init", {143'd0, data_fifo_init}, '0);
        check("rst_valid", {143'd0, out_valid}, '0);
        check("rst_last", {143'd0, out_last}, '0);
        rst_n = 1'b1;
        tick();

        // Preloaded 8 beats at full rate.
        preload(8);
        out_ready = 1'b1;
        start(8);
        tick();
        #3;
        check("no_valid_cycle1", {143'd0, out_valid}, '0);
        tick();
        #3;
        check("first_valid_cycle2", {143'd0, out_valid}, 144'd1);
        repeat (8) tick();
        #3;
        check("full_rate_done", {143'd0, xfer_done}, 144'd1);
        check("full_rate_idle", {143'd0, busy}, '0);
        check("full_rate_fires", FW'(fires_x), FW'(8));
        check("full_rate_pops", FW'(pops_x), FW'(8));
        tick();

        // Backpressure toggling 1010.
        preload(4);
        start(4);
        for (int i = 0; i < 40 && !done_seen; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        check("toggle_done", {143'd0, done_seen}, 144'd1);
        check("toggle_pops", FW'(pops_x), FW'(4));
        out_ready = 1'b1;
        tick();

        // FIFO runs dry for 5 cycles mid-transfer.
        push_word(1'b0); push_word(1'b0);
        start(6);
        repeat (4) tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            #3;
            check("dry_no_pop", {143'd0, data_fifo_pop}, '0);
        end
        check("dry_valid_low", {143'd0, out_valid}, '0);
        check("dry_busy", {143'd0, busy}, 144'd1);
        for (int i = 0; i < 4; i++) push_word(i == 3);
        wait_done(40);
        tick();

        // Abort after 3 of 10 beats.
        preload(10);
        start(10);
        for (int i = 0; i < 30 && fires_x < 3; i++) tick();
        check("abort_reached_3", FW'(fires_x), FW'(3));
        out_ready = 1'b0;
        xfer_abort = 1'b1;
        tick();
        xfer_abort = 1'b0;
        exp_q.delete();
        load_chk = 1'b0;
        #3;
        check("abort_init", {143'd0, data_fifo_init}, 144'd1);
        check("abort_valid", {143'd0, out_valid}, '0);
        check("abort_busy", {143'd0, busy}, 144'd1);
        check("abort_no_pop", {143'd0, data_fifo_pop}, '0);
        tick();
        #3;
        check("abort_idle", {143'd0, busy}, '0);
        check("abort_init_once", {143'd0, data_fifo_init}, '0);
        check("abort_no_done", {143'd0, xfer_done}, '0);
        out_ready = 1'b1;
        // Abort in IDLE is ignored.
        xfer_abort = 1'b1;
        tick();
        xfer_abort = 1'b0;
        #3;
        check("idle_abort_init", {143'd0, data_fifo_init}, '0);
        check("idle_abort_busy", {143'd0, busy}, '0);

        // Abort coincident with the last beat: completion wins.
        preload(2);
        out_ready = 1'b0;
        start(2);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        xfer_abort = 1'b1;
        tick();
        xfer_abort = 1'b0;
        #3;
        check("coinc_done", {143'd0, xfer_done}, 144'd1);
        check("coinc_no_init", {143'd0, data_fifo_init}, '0);
        check("coinc_idle", {143'd0, busy}, '0);
        tick();

        // Ignored starts: N=0 in IDLE, and any start while running.
        xfer_beats = '0;
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        #3;
        check("n0_busy", {143'd0, busy}, '0);
        check("n0_pop", {143'd0, data_fifo_pop}, '0);
        preload(3);
        out_ready = 1'b0;
        start(3);
        repeat (4) tick();
        xfer_beats = BW'(7);
        xfer_start = 1'b1;
        tick();
        xfer_start = 1'b0;
        out_ready = 1'b1;
        wait_done(30);
        check("restart_pops", FW'(pops_x), FW'(3));
        tick();

        // Reset mid-transfer.
        preload(8);
        start(8);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        #3;
        check("mid_rst_busy", {143'd0, busy}, '0);
        check("mid_rst_done", {143'd0, xfer_done}, '0);
        check("mid_rst_pop", {143'd0, data_fifo_pop}, '0);
        check("mid_rst_init", {143'd0, data_fifo_init}, '0);
        check("mid_rst_valid", {143'd0, out_valid}, '0);
        check("mid_rst_last", {143'd0, out_last}, '0);
        rst_n = 1'b1;
        fq.delete();
        exp_q.delete();
        data_fifo_valid = 1'b0;
        data_fifo_empty = 1'b1;
        load_chk = 1'b0;
        tick();
        #3;
        check("post_rst_init", {143'd0, data_fifo_init}, '0);

        // Randomized transfers with gaps, backpressure and occasional abort.
        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(1, 12);
            k = $urandom_range(0, n);
            do_abort = ($urandom_range(0, 3) == 0) && (n > 2);
            abort_at = $urandom_range(0, n - 2);
            aborted = 1'b0;
            for (int i = 0; i < k; i++) push_word(i == n - 1);
            pushed = k;
            start(n);
            for (int c = 0; c < 300 && !done_seen && !aborted; c++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                if (pushed < n && $urandom_range(0, 2) != 0) begin
                    push_word(pushed == n - 1);
                    pushed++;
                end
                if (do_abort && busy && fires_x >= abort_at && fires_x < n - 1) begin
                    xfer_abort = 1'b1;
                    tick();
                    xfer_abort = 1'b0;
                    exp_q.delete();
                    load_chk = 1'b0;
                    aborted = 1'b1;
                    tick();
                    #3;
                    check("rnd_abort_idle", {143'd0, busy}, '0);
                end else begin
                    tick();
                end
            end
            if (!aborted) begin
                out_ready = 1'b1;
                while (pushed < n) begin
                    push_word(pushed == n - 1);
                    pushed++;
                end
                wait_done(60);
                check("rnd_pops", FW'(pops_x), FW'(n));
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/idma_rd_data_drain_128b.md
IDMA_RD_DATA_DRAIN_128B -- requirements
Module: idma_rd_data_drain_128b

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 144, meaning FIFO word width (128 data + 16 strobe).
REQ-002 SHALL have parameter DATA_W, default 128, meaning payload width in bits (bits [127:0] of a FIFO word).
REQ-003 SHALL have parameter STRB_W, default 16, meaning byte-strobe width (bits [143:128] of a FIFO word).
REQ-004 SHALL have parameter BEAT_W, default 16, meaning transfer-length counter width.
REQ-005 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- xfer_start  in  1  start pulse.
- xfer_beats  in  BEAT_W  beat count N, sampled with xfer_start.
- xfer_abort  in  1  abort pulse.
- busy  out  1  transfer in progress.
- xfer_done  out  1  one-cycle completion pulse.
- data_fifo_pop  out  1  FIFO pop request.
- data_fifo_valid  in  1  FIFO read data valid.
- data_fifo_data_out  in  FIFO_WIDTH  FIFO read data.
- data_fifo_empty  in  1  FIFO empty.
- data_fifo_init  out  1  FIFO flush pulse.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  beat payload.
- out_strb  out  STRB_W  beat byte strobes.
- out_last  out  1  final beat of transfer.

Function
REQ-006 SHALL treat the FIFO as one-cycle read latency: a pop at cycle t yields data_fifo_valid with data at t+1.
REQ-007 SHALL implement states IDLE, RUN, ABORT; IDLE->RUN on xfer_start with xfer_beats!=0; xfer_start with xfer_beats==0 or in RUN/ABORT SHALL be ignored.
REQ-008 SHALL assert data_fifo_pop only when state==RUN, !data_fifo_empty, popped<N, and (occupancy + inflight - out_fire) < 2; pop is never issued on empty.
REQ-009 SHALL capture every data_fifo_valid word into a 2-entry skid buffer; overflow is impossible by REQ-008.
REQ-010 SHALL present the buffer head on out_valid/out_data/out_strb; a beat transfers on out_valid && out_ready; out_data/out_strb/out_last SHALL hold stable while out_valid && !out_ready.
REQ-011 SHALL sustain one beat per cycle when the FIFO is non-empty and out_ready is held high (first beat at out_valid 2 cycles after xfer_start).
REQ-012 SHALL assert out_last on the beat where the sent count == N-1.
REQ-013 SHALL pulse xfer_done the cycle after the out_last transfer and return to IDLE on that same edge; busy=1 in RUN and ABORT.
REQ-014 SHALL, on xfer_abort in RUN, enter ABORT, stop popping, discard buffer contents and any in-flight word, and pulse data_fifo_init for one cycle.
REQ-015 SHALL return from ABORT to IDLE after exactly one cycle, with no xfer_done pulse; xfer_abort in IDLE SHALL be ignored.
REQ-016 SHALL, on simultaneous xfer_abort and out_last transfer, treat the beat as delivered and give completion priority (xfer_done pulses, no ABORT).
REQ-017 SHALL count popped and sent beats modulo 2^BEAT_W, with N up to 2^BEAT_W-1.

Reset
REQ-018 SHALL, while rst_n==0 at a clock edge, set state IDLE, clear counters and buffer, and drive busy, xfer_done, data_fifo_pop, data_fifo_init, out_valid, and out_last to 0.
REQ-019 SHALL, on reset mid-transfer, drop all buffered data without issuing data_fifo_init; the FIFO is reset by its own rst_n.

Structure
REQ-020 SHALL take FIFO_WIDTH, DATA_W, STRB_W, and the state encoding from shared package idma_rd_pkg.
REQ-021 SHALL instantiate one sub-module idma_skid_buf_2e (2-entry buffer with occupancy output) for the output buffer.

Verification
REQ-022 SHALL cover this scenario: FIFO preloaded with 8 words, N=8, out_ready=1 -> 8 consecutive beats, out_last on beat 8, xfer_done 1 cycle later, 8 pops total.
REQ-023 SHALL cover this scenario: N=4, out_ready toggled 1010 -> data order preserved, no pop on empty, and never more than 2 buffered+inflight words.
REQ-024 SHALL cover this scenario: FIFO empty for 5 cycles mid-transfer -> data_fifo_pop=0 throughout and out_valid deasserts once the buffer drains.
REQ-025 SHALL cover this scenario: abort after 3 of 10 beats -> data_fifo_init pulses once, out_valid=0 next cycle, IDLE after 1 cycle, no xfer_done.
REQ-026 SHALL cover this scenario: xfer_start with N=0, and xfer_start during RUN -> ignored, and the state and counters are unchanged.
REQ-027 SHALL cover this scenario: rst_n low for 1 cycle mid-transfer -> all outputs 0 next cycle and state IDLE.
